// File: rtl/at24c02_page_sched.sv
// rtl/at24c02_page_sched.sv - splits byte requests into page-aligned AT24C02 controller segments
// Optional post-write wait state enabled by defining AT24C02_SCHED_TWR_EN.
module at24c02_page_sched #(
  parameter int PAGE_SIZE     = 8,
  parameter int TWR_CYCLES    = 250000,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_len_m1,
  input  logic [7:0]  wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic [7:0]  rdata,
  output logic        rvalid,
  input  logic        rready,
  output logic        busy,
  output logic        done,
  output logic [10:0] ctl_address,
  output logic        ctl_wr_en,
  output logic [7:0]  ctl_din,
  output logic        ctl_last,
  output logic        ctl_parent_ready,
  input  logic [7:0]  ctl_dout,
  input  logic        ctl_ready
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [8:0] PAGE_SZ   = 9'(PAGE_SIZE);
  localparam logic [8:0] PAGE_MASK = 9'(PAGE_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE, START, XFER, SETTLE, TWR_WAIT, DONE
  } state_t;

  state_t          state_q, state_d;
  logic            wr_q, wr_d;
  logic [7:0]      seg_addr_q, seg_addr_d;
  logic [8:0]      remaining_q, remaining_d;
  logic [8:0]      seg_cnt_q, seg_cnt_d;
  logic [8:0]      seg_len_q, seg_len_d;
  logic [SW-1:0]   settle_cnt_q, settle_cnt_d;

  logic [8:0]      page_room;
  logic [8:0]      seg_len_calc;
  logic            beat;

`ifdef AT24C02_SCHED_TWR_EN
  localparam int TW = $clog2(TWR_CYCLES + 1);
  localparam logic [TW-1:0] TWR_LAST = TW'(TWR_CYCLES - 1);
  logic [TW-1:0]   twr_cnt_q, twr_cnt_d;
`endif

  // Writes stop at the page boundary; reads stream the whole request in one go.
  always_comb begin
    page_room = PAGE_SZ - ({1'b0, seg_addr_q} & PAGE_MASK);
    if (!wr_q || (remaining_q < page_room)) begin
      seg_len_calc = remaining_q;
    end else begin
      seg_len_calc = page_room;
    end
  end

  always_comb begin
    state_d          = state_q;
    wr_d             = wr_q;
    seg_addr_d       = seg_addr_q;
    remaining_d      = remaining_q;
    seg_cnt_d        = seg_cnt_q;
    seg_len_d        = seg_len_q;
    settle_cnt_d     = settle_cnt_q;
`ifdef AT24C02_SCHED_TWR_EN
    twr_cnt_d        = twr_cnt_q;
`endif
    req_ready        = 1'b0;
    busy             = (state_q != IDLE);
    done             = 1'b0;
    wready           = 1'b0;
    rvalid           = 1'b0;
    rdata            = 8'h00;
    ctl_address      = 11'd0;
    ctl_wr_en        = 1'b0;
    ctl_din          = 8'h00;
    ctl_last         = 1'b0;
    ctl_parent_ready = 1'b0;
    beat             = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d        = req_wr;
          seg_addr_d  = req_addr;
          remaining_d = {1'b0, req_len_m1} + 9'd1;
          state_d     = START;
        end
      end

      START: begin
        ctl_parent_ready = 1'b1;
        ctl_address      = {3'b000, seg_addr_q};
        ctl_wr_en        = wr_q;
        if (ctl_ready) begin
          seg_cnt_d = seg_len_calc;
          seg_len_d = seg_len_calc;
          state_d   = XFER;
        end
      end

      XFER: begin
        ctl_address = {3'b000, seg_addr_q};
        ctl_wr_en   = wr_q;
        ctl_last    = (seg_cnt_q == 9'd1);
        if (wr_q) begin
          ctl_din          = wdata;
          ctl_parent_ready = wvalid;
          wready           = ctl_ready;
          beat             = wvalid && ctl_ready;
        end else begin
          rdata            = ctl_dout;
          rvalid           = ctl_ready;
          ctl_parent_ready = rready;
          beat             = ctl_ready && rready;
        end
        if (beat) begin
          seg_cnt_d   = seg_cnt_q - 9'd1;
          remaining_d = remaining_q - 9'd1;
          if (seg_cnt_q == 9'd1) begin
            // A 256-byte segment adds zero, which is the correct wrap.
            seg_addr_d   = 8'({1'b0, seg_addr_q} + seg_len_q);
            settle_cnt_d = '0;
            state_d      = SETTLE;
          end
        end
      end

      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
`ifdef AT24C02_SCHED_TWR_EN
          if (wr_q) begin
            twr_cnt_d = '0;
            state_d   = TWR_WAIT;
          end else begin
            state_d = DONE;
          end
`else
          state_d = (remaining_q != 9'd0) ? START : DONE;
`endif
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      TWR_WAIT: begin
`ifdef AT24C02_SCHED_TWR_EN
        if (twr_cnt_q == TWR_LAST) begin
          state_d = (remaining_q != 9'd0) ? START : DONE;
        end else begin
          twr_cnt_d = twr_cnt_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      seg_addr_q   <= 8'h00;
      remaining_q  <= 9'd0;
      seg_cnt_q    <= 9'd0;
      seg_len_q    <= 9'd0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      seg_addr_q   <= seg_addr_d;
      remaining_q  <= remaining_d;
      seg_cnt_q    <= seg_cnt_d;
      seg_len_q    <= seg_len_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

`ifdef AT24C02_SCHED_TWR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      twr_cnt_q <= '0;
    end else begin
      twr_cnt_q <= twr_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_at24c02_page_sched.sv
// tb/tb_at24c02_page_sched.sv - request table plus beat/segment scoreboard for at24c02_page_sched
module tb_at24c02_page_sched;

  localparam int PAGE   = 8;
  localparam int TWR    = 12;
  localparam int SETTLE = 4;
`ifdef AT24C02_SCHED_TWR_EN
  localparam int TWR_GAP = TWR;
`else
  localparam int TWR_GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [7:0]  req_addr, req_len_m1;
  logic [7:0]  wdata;
  logic        wvalid, wready;
  logic [7:0]  rdata;
  logic        rvalid, rready;
  logic        busy, done;
  logic [10:0] ctl_address;
  logic        ctl_wr_en;
  logic [7:0]  ctl_din;
  logic        ctl_last, ctl_parent_ready;
  logic [7:0]  ctl_dout;
  logic        ctl_ready;

  at24c02_page_sched #(
    .PAGE_SIZE(PAGE), .TWR_CYCLES(TWR), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_len_m1(req_len_m1),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .busy(busy), .done(done),
    .ctl_address(ctl_address), .ctl_wr_en(ctl_wr_en), .ctl_din(ctl_din),
    .ctl_last(ctl_last), .ctl_parent_ready(ctl_parent_ready),
    .ctl_dout(ctl_dout), .ctl_ready(ctl_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [7:0] data;
    bit         last;
  } beat_t;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] len_m1;
    int         stall_after;
    int         stall_len;
    bit         hold_valid;
    bit         cr_mode;
    int         exp_segs;
  } req_t;

  beat_t      beat_q[$];
  logic [7:0] start_q[$];
  logic [7:0] eeprom [256];
  logic [7:0] golden [256];
  logic [7:0] ptr = 8'h00;
  int  cyc = 0, last_end = 0;
  int  starts_seen = 0, beats_seen = 0, done_seen = 0;
  bit  have_end = 0, cur_wr = 0, cr_mode = 0;
  int  n_checks = 0, n_pass = 0;

  assign ctl_dout = eeprom[ptr];

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  initial begin
    ctl_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ctl_ready = cr_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Controller-side monitor: start commands, data beats, completion timing.
  always @(negedge clk) begin
    beat_t b;
    int    gap;
    cyc++;
    if (!rst) begin
      if (done) begin
        done_seen++;
        check("done_gap", cyc - last_end, SETTLE + 1 + (cur_wr ? TWR_GAP : 0));
      end
      if (req_valid) check("req_ready", int'(req_ready), int'(!busy));
      if (!busy || !cur_wr) check("wready_off", int'(wready), 0);
      if (!busy || cur_wr) check("rvalid_off", int'(rvalid), 0);
      if (ctl_parent_ready && ctl_ready && !wready && !rvalid) begin
        starts_seen++;
        check("start_wr_en", int'(ctl_wr_en), int'(cur_wr));
        if (start_q.size() == 0) check("start_extra", 1, 0);
        else check("start_addr", int'(ctl_address), int'({3'b000, start_q.pop_front()}));
        if (have_end) begin
          gap = cyc - last_end;
          if (cr_mode) check("start_gap_min", int'(gap >= SETTLE + 1 + TWR_GAP), 1);
          else check("start_gap", gap, SETTLE + 1 + TWR_GAP);
        end
        ptr = ctl_address[7:0];
      end
      if ((wvalid && wready) || (rvalid && rready)) begin
        beats_seen++;
        check("parent_ready", int'(ctl_parent_ready), 1);
        if (beat_q.size() == 0) check("beat_extra", 1, 0);
        else begin
          b = beat_q.pop_front();
          check("beat_dir", int'(wvalid && wready), int'(b.wr));
          check(b.wr ? "wr_data" : "rd_data", int'(b.wr ? ctl_din : rdata), int'(b.data));
          check("ctl_last", int'(ctl_last), int'(b.last));
          if (b.last) begin
            last_end = cyc;
            have_end = 1'b1;
          end
        end
        if (wvalid && wready) eeprom[ptr] = ctl_din;
        ptr = ptr + 8'd1;
      end else if (ctl_last) begin
        check("last_early", int'(beat_q.size() > 0 && beat_q[0].last), 1);
      end
    end
  end

  task automatic run_req(input req_t r, input int abort_wait);
    logic [7:0] data[$];
    beat_t      eb;
    logic [7:0] a;
    int n, rem, segs, idx, len, sent, stall_left, budget, d0, s0, b0, acnt;
    bit fin, act, wb, rb, armed;
    n = int'(r.len_m1) + 1;
    a = r.addr; rem = n; segs = 0; idx = 0;
    sent = 0; stall_left = 0; budget = 0; acnt = 0; fin = 0; armed = 0;
    for (int i = 0; i < n; i++) data.push_back(r.wr ? 8'($urandom) : golden[8'(int'(r.addr) + i)]);
    while (rem > 0) begin
      len = rem;
      if (r.wr && (PAGE - int'(a) % PAGE) < rem) len = PAGE - int'(a) % PAGE;
      start_q.push_back(a);
      for (int k = 0; k < len; k++) begin
        eb.wr = r.wr; eb.data = data[idx]; eb.last = (k == len - 1);
        beat_q.push_back(eb);
        if (r.wr) golden[8'(int'(a) + k)] = data[idx];
        idx++;
      end
      a = 8'(int'(a) + len);
      rem -= len;
      segs++;
    end
    d0 = done_seen; s0 = starts_seen; b0 = beats_seen;
    @(posedge clk); #1;
    cur_wr = r.wr; cr_mode = r.cr_mode; have_end = 0;
    req_valid = 1'b1; req_wr = r.wr; req_addr = r.addr; req_len_m1 = r.len_m1;
    @(posedge clk); #1;
    if (r.hold_valid) begin
      req_addr = ~r.addr; req_wr = !r.wr;
    end else req_valid = 1'b0;
    wvalid = r.wr; wdata = data[0]; rready = !r.wr;
    while (!fin) begin
      @(negedge clk);
      wb = wvalid && wready;
      rb = rvalid && rready;
      if (done) fin = 1;
      budget++;
      if (budget > 3000) begin
        check("timeout", 1, 0);
        fin = 1;
      end
      if (abort_wait > 0) begin
        if ((wb || rb) && ctl_last) armed = 1;
        else if (armed) begin
          acnt++;
          if (acnt == abort_wait) begin
            @(posedge clk); #1;
            rst = 1'b1; req_valid = 1'b0; wvalid = 1'b0; rready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            check("rst_req_ready", int'(req_ready), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_done", int'(done), 0);
            check("rst_wready", int'(wready), 0);
            check("rst_rvalid", int'(rvalid), 0);
            check("rst_parent_ready", int'(ctl_parent_ready), 0);
            check("rst_ctl_last", int'(ctl_last), 0);
            check("rst_ctl_wr_en", int'(ctl_wr_en), 0);
            check("rst_ctl_address", int'(ctl_address), 0);
            beat_q.delete(); start_q.delete(); have_end = 0;
            d0 = done_seen; s0 = starts_seen;
            repeat (40) @(negedge clk);
            check("rst_no_done", done_seen - d0, 0);
            check("rst_no_start", starts_seen - s0, 0);
            return;
          end
        end
      end
      if (!fin) begin
        @(posedge clk); #1;
        if (wb || rb) begin
          sent++;
          if (sent == r.stall_after) stall_left = r.stall_len;
        end
        if (stall_left > 0) begin
          act = 0;
          stall_left--;
        end else act = (sent < n);
        if (r.wr) begin
          wvalid = act;
          wdata  = (sent < n) ? data[sent] : 8'h00;
        end else rready = act;
      end
    end
    check("starts_model", starts_seen - s0, segs);
    check("starts_table", starts_seen - s0, r.exp_segs);
    check("beats", beats_seen - b0, n);
    check("queues_empty", beat_q.size() + start_q.size(), 0);
    @(posedge clk); #1;
    req_valid = 1'b0; wvalid = 1'b0; rready = 1'b0; cr_mode = 0;
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("done_count", done_seen - d0, 1);
  endtask

  req_t tbl[12];
  req_t extra;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = 8'h00; req_len_m1 = 8'h00;
    wdata = 8'h00; wvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      eeprom[i] = 8'(i * 7 + 3);
      golden[i] = 8'(i * 7 + 3);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("init_req_ready", int'(req_ready), 1);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    check("init_wready", int'(wready), 0);
    check("init_rvalid", int'(rvalid), 0);
    check("init_parent_ready", int'(ctl_parent_ready), 0);
    check("init_ctl_last", int'(ctl_last), 0);
    check("init_ctl_wr_en", int'(ctl_wr_en), 0);
    check("init_ctl_address", int'(ctl_address), 0);

    //         wr  addr   len_m1  st_after st_len hold cr  segs
    tbl[0]  = '{1, 8'h05, 8'd9,   0, 0, 0, 0, 2};
    tbl[1]  = '{1, 8'hFC, 8'd7,   0, 0, 0, 0, 2};
    tbl[2]  = '{0, 8'hFE, 8'd3,   0, 0, 0, 0, 1};
    tbl[3]  = '{1, 8'h10, 8'd7,   3, 5, 0, 0, 1};
    tbl[4]  = '{1, 8'h00, 8'd15,  0, 0, 0, 0, 2};
    tbl[5]  = '{0, 8'h05, 8'd9,   2, 3, 1, 0, 1};
    tbl[6]  = '{1, 8'h00, 8'd255, 0, 0, 0, 0, 32};
    tbl[7]  = '{0, 8'h00, 8'd255, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 8'h07, 8'd0,   0, 0, 0, 0, 1};
    tbl[9]  = '{1, 8'hFF, 8'd1,   0, 0, 1, 0, 2};
    tbl[10] = '{1, 8'h03, 8'd12,  0, 0, 0, 1, 2};
    tbl[11] = '{0, 8'h03, 8'd12,  4, 2, 0, 1, 1};

    for (int i = 0; i < 12; i++) run_req(tbl[i], 0);

    // Reset in the gap between the two pages of a 16-byte write.
    extra = '{1, 8'h40, 8'd15, 0, 0, 0, 0, 2};
    run_req(extra, (TWR_GAP > 0) ? SETTLE + 3 : 2);

    extra = '{1, 8'h30, 8'd5, 0, 0, 0, 0, 1};
    run_req(extra, 0);
    extra = '{0, 8'h30, 8'd5, 0, 0, 0, 0, 1};
    run_req(extra, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/at24c02_page_sched.md
AT24C02_PAGE_SCHED -- requirements
Module: at24c02_page_sched

Interface
REQ-001 PAGE_SIZE, 8, EEPROM write-page size in bytes; power of two, 2..256.
REQ-002 TWR_CYCLES, 250000, clk cycles waited after each write segment (5 ms at 50 MHz).
REQ-003 SETTLE_CYCLES, 4, minimum idle cycles after any segment's final beat before the next start.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  request handshake; accepted when both high.
REQ-007 req_wr  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  8  first EEPROM byte address.
REQ-009 req_len_m1  in  8  byte count minus one (1..256 bytes).
REQ-010 wdata / wvalid / wready  in / in / out  8 / 1 / 1  write-data stream.
REQ-011 rdata / rvalid / rready  out / out / in  8 / 1 / 1  read-data stream.
REQ-012 busy / done  out  1 / 1  busy = not IDLE; done = one-cycle completion pulse.
REQ-013 ctl_address  out  11  {3'b0, segment address} to the EEPROM controller.
REQ-014 ctl_wr_en / ctl_din / ctl_last / ctl_parent_ready  out  1 / 8 / 1 / 1  controller command and data inputs.
REQ-015 ctl_dout / ctl_ready  in  8 / 1  controller read data and ready.

Function
REQ-016 States SHALL be IDLE, START, XFER, SETTLE, TWR_WAIT, DONE.
REQ-017 IDLE: req_ready=1; on accept, latch req_wr, req_addr and total = req_len_m1+1 (9-bit); go to START.
REQ-018 Write segment length SHALL be min(remaining, PAGE_SIZE - (seg_addr mod PAGE_SIZE)); a read is one segment of the full length.
REQ-019 START: ctl_parent_ready=1 with ctl_address and ctl_wr_en driven; the cycle ctl_ready=1, go to XFER with seg_cnt = segment length.
REQ-020 XFER write: ctl_din=wdata, ctl_parent_ready=wvalid, wready=ctl_ready; a beat is wvalid&&wready.
REQ-021 XFER read: rdata=ctl_dout, rvalid=ctl_ready, ctl_parent_ready=rready; a beat is rvalid&&rready.
REQ-022 Each beat decrements seg_cnt and remaining; ctl_last=1 combinationally while seg_cnt==1; the beat at seg_cnt==1 ends the segment.
REQ-023 Segment end: seg_addr += segment length modulo 256 (0xFF wraps to 0x00); go to SETTLE.
REQ-024 SETTLE: all ctl_* strobes, wready and rvalid low for SETTLE_CYCLES; then TWR_WAIT if write, else DONE; a write with remaining>0 returns to START via TWR_WAIT.
REQ-025 TWR_WAIT: count TWR_CYCLES; then START if remaining>0, else DONE.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; a new request can be accepted the following cycle.
REQ-027 Stalls (wvalid=0 or rready=0) SHALL produce no beat and leave ctl_last and counters unchanged, for any duration.
REQ-028 wready and rvalid SHALL be 0 outside XFER and in the direction not selected.
REQ-029 req_valid in any state other than IDLE SHALL be ignored (req_ready=0).

Reset
REQ-030 rst SHALL force IDLE and clear all counters; reset outputs: req_ready=1, busy=0, done=0, wready=0, rvalid=0, ctl_parent_ready=0, ctl_last=0, ctl_wr_en=0, ctl_address=0.
REQ-031 rst asserted mid-operation SHALL abandon the request without a done pulse; the controller shares the same rst.

Configuration
REQ-032 Macro AT24C02_SCHED_TWR_EN defined: TWR_WAIT behaves per REQ-025.
REQ-033 Macro undefined: TWR_WAIT and its counter are removed; SETTLE goes directly to START or DONE.

Verification
REQ-034 Write addr 0x05, len_m1=9 -> segments (0x005, 3 bytes) and (0x008, 7 bytes); ctl_last on bytes 3 and 10; TWR_CYCLES gap after each; one done.
REQ-035 Write addr 0xFC, len_m1=7 -> segments (0x0FC, 4) then (0x000, 4); wrap is correct.
REQ-036 Read addr 0xFE, len_m1=3 -> one start at 0x0FE, 4 rvalid&&rready beats, ctl_last on the 4th, done after SETTLE_CYCLES.
REQ-037 Write 8 bytes at 0x10 with wvalid low for 5 cycles after byte 3 -> no extra beats and no early ctl_last; exactly 8 beats; done.
REQ-038 rst for 1 cycle during TWR_WAIT -> next cycle all outputs at reset values, req_ready=1, no done; a new request then completes normally.
REQ-039 Macro undefined with a 16-byte write at 0x00 -> two 8-byte segments separated only by SETTLE_CYCLES.
